ysyx_22040729_alu_seq_divider: RTL and testbench

//  Multi-cycle radix-2 restoring divider answering DIV/DIVU/REM/REMU and W-variant requests from the ALU.
//  The execute stage issues one request; the block iterates one quotient bit per cycle.
//  It returns quotient and remainder together with RISC-V-compliant special-case handling.

---
 rtl/ysyx_22040729_alu_seq_divider.sv | 158 +++++++++++++++
 tb/tb_ysyx_22040729_alu_seq_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040729_alu_seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and their W variants.
// One request is in flight at a time. Normal ops take one cycle per quotient bit.
// Divide-by-zero and signed overflow finish in a single cycle with RISC-V results.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               synchronous abort of any in-flight op; beats out_ready/in_valid
//   in_valid/in_ready   request handshake; operands and flags sampled on accept only
//   dividend, divisor   source operands (low half only for word ops)
//   is_signed, is_word  operation select
//   out_valid/out_ready result handshake; results held stable until accepted
//   quotient, remainder sign-corrected results, sign-extended from the low half for word ops
module ysyx_22040729_alu_seq_divider #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  is_signed,
  input  logic                  is_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned Width = DATA_WIDTH;
  localparam int unsigned Half  = DATA_WIDTH / 2;
  localparam int unsigned CntW  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [Width-1:0]  rem_q, quo_q, dsr_q;
  logic              q_neg_q, r_neg_q, word_q;

  function automatic logic [Width-1:0] sext_half(input logic [Half-1:0] v);
    return {{Half{v[Half-1]}}, v};
  endfunction

  // Operand preparation, evaluated on the accept cycle.
  logic [Width-1:0] a_ext, b_ext, a_mag, b_mag, min_val, sp_q, sp_r;
  logic             a_neg, b_neg, div_zero, sgn_ovf;

  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (is_word) begin
      a_ext = is_signed ? sext_half(dividend[Half-1:0]) : {{Half{1'b0}}, dividend[Half-1:0]};
      b_ext = is_signed ? sext_half(divisor[Half-1:0])  : {{Half{1'b0}}, divisor[Half-1:0]};
    end
    a_neg    = is_signed & a_ext[Width-1];
    b_neg    = is_signed & b_ext[Width-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    // Most-negative value at the op width, already extended to full width.
    min_val  = is_word ? {{(Half + 1){1'b1}}, {(Half - 1){1'b0}}} : {1'b1, {(Width - 1){1'b0}}};
    div_zero = (b_ext == '0);
    sgn_ovf  = is_signed && (b_ext == '1) && (a_ext == min_val);
    sp_q     = div_zero ? '1 : a_ext;
    sp_r     = div_zero ? a_ext : '0;
    if (is_word) begin
      sp_q = sext_half(sp_q[Half-1:0]);
      sp_r = sext_half(sp_r[Half-1:0]);
    end
  end

  // One restoring step. The partial remainder is always below 2*divisor, so a
  // Width+1 bit subtraction with its top bit as sign is exact.
  logic [Width:0]   shifted, trial;
  logic [Width-1:0] rem_nx, quo_nx, q_fin, r_fin;

  always_comb begin
    shifted = {rem_q, quo_q[Width-1]};
    trial   = shifted - {1'b0, dsr_q};
    if (!trial[Width]) begin
      rem_nx = trial[Width-1:0];
      quo_nx = {quo_q[Width-2:0], 1'b1};
    end else begin
      rem_nx = shifted[Width-1:0];
      quo_nx = {quo_q[Width-2:0], 1'b0};
    end
    q_fin = q_neg_q ? -quo_nx : quo_nx;
    r_fin = r_neg_q ? -rem_nx : rem_nx;
    if (word_q) begin
      q_fin = sext_half(q_fin[Half-1:0]);
      r_fin = sext_half(r_fin[Half-1:0]);
    end
  end

  assign in_ready = (state_q == StIdle) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      word_q    <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q  <= is_word;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dsr_q   <= b_mag;
            rem_q   <= '0;
            // Word ops run only Half steps, so park the dividend in the upper half.
            quo_q   <= is_word ? (a_mag << Half) : a_mag;
            cnt_q   <= is_word ? CntW'(Half) : CntW'(Width);
            if (div_zero || sgn_ovf) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              quotient  <= sp_q;
              remainder <= sp_r;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040729_alu_seq_divider.sv
module tb_ysyx_22040729_alu_seq_divider;

  logic        clk, rst, flush, in_valid, in_ready, is_signed, is_word, out_valid, out_ready;
  logic [63:0] dividend, divisor, quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  ysyx_22040729_alu_seq_divider #(.DATA_WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .is_word   (is_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: RISC-V division semantics from plain integer arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  input logic w, output logic [63:0] q, output logic [63:0] r,
                                  output logic special);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    q32 = '0;
    r32 = '0;
    special = 1'b0;
    q = '0;
    r = '0;
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; special = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0; special = 1'b1;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; special = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0; special = 1'b1;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: tracks the expected transaction and checks outputs every cycle.
  logic [63:0] exp_q, exp_r, pq, pr;
  logic        pending, seen, psp;
  int          lat_cnt, exp_lat;

  initial begin
    pending = 1'b0;
    seen    = 1'b0;
    lat_cnt = 0;
    exp_lat = 0;
    exp_q   = '0;
    exp_r   = '0;
    // Hand-computed pins for the reference model.
    ref_div(64'd100, 64'd7, 1'b0, 1'b0, pq, pr, psp);
    chk("pin_divu_q", pq, 64'd14);
    chk("pin_divu_r", pr, 64'd2);
    ref_div(-64'sd7, 64'd2, 1'b1, 1'b0, pq, pr, psp);
    chk("pin_div_q", pq, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_div_r", pr, 64'hFFFF_FFFF_FFFF_FFFF);
    ref_div(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, pq, pr, psp);
    chk("pin_ovf_q", pq, 64'h8000_0000_0000_0000);
    chk("pin_ovf_r", pr, 64'd0);
    ref_div(64'hDEAD_0000_0000_0009, 64'd0, 1'b0, 1'b1, pq, pr, psp);
    chk("pin_divuw0_q", pq, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_divuw0_r", pr, 64'h0000_0000_0000_0009);
    ref_div(64'h0000_0000_8000_0001, 64'd1, 1'b1, 1'b1, pq, pr, psp);
    chk("pin_divw_q", pq, 64'hFFFF_FFFF_8000_0001);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_remainder", remainder, 64'd0);
        pending = 1'b0;
      end else begin
        if (pending) lat_cnt++;
        chk("in_ready", {63'd0, in_ready}, {63'd0, !pending});
        if (out_valid) begin
          if (!pending) begin
            chk("spurious_valid", {63'd0, out_valid}, 64'd0);
          end else begin
            if (!seen) chk("latency", 64'(lat_cnt), 64'(exp_lat));
            seen = 1'b1;
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
          end
        end else if (pending && seen) begin
          chk("valid_held", {63'd0, out_valid}, 64'd1);
        end
        if (pending && !seen && lat_cnt > 70) begin
          chk("latency_timeout", 64'(lat_cnt), 64'(exp_lat));
          pending = 1'b0;
        end
        if (flush) begin
          pending = 1'b0;
        end else if (pending && out_valid && out_ready) begin
          pending = 1'b0;
        end else if (!pending && in_valid) begin
          ref_div(dividend, divisor, is_signed, is_word, exp_q, exp_r, psp);
          exp_lat = psp ? 1 : (is_word ? 33 : 65);
          pending = 1'b1;
          seen    = 1'b0;
          lat_cnt = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                       input logic rdy);
    tick(1);
    dividend = a; divisor = b; is_signed = s; is_word = w; in_valid = 1'b1; out_ready = rdy;
    tick(1);
    // Scramble inputs after accept; the DUT must ignore them.
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    is_signed = 1'($urandom_range(0, 1));
    is_word   = 1'($urandom_range(0, 1));
  endtask

  task automatic op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                    input int hold);
    int n;
    start(a, b, s, w, hold == 0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick(1);
      n++;
    end
    tick(hold);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] a, b;
    logic        s, w;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0; is_word = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    op(64'd100, 64'd7, 1'b0, 1'b0, 0);
    op(-64'sd7, 64'd2, 1'b1, 1'b0, 0);
    op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 0);
    op(64'hDEAD_0000_0000_0009, 64'd0, 1'b0, 1'b1, 0);
    op(64'h0000_0000_8000_0001, 64'd1, 1'b1, 1'b1, 0);
    op(64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 0);
    op(64'd12345, 64'd0, 1'b1, 1'b0, 0);

    // Result held while out_ready stays low.
    op(64'd1000, 64'd33, 1'b0, 1'b0, 10);

    // Flush mid-CALC: nothing may come out afterwards.
    start(64'd999_999, 64'd7, 1'b0, 1'b0, 1'b1);
    tick(10);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(80);

    // Flush in DONE, then flush together with a request while idle.
    start(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    dividend = 64'd50; divisor = 64'd5; in_valid = 1'b1; flush = 1'b1;
    tick(1);
    in_valid = 1'b0; flush = 1'b0;
    tick(5);

    // Reset during CALC, then a fresh request.
    start(64'hFFFF_0000_1234_5678, 64'd13, 1'b0, 1'b0, 1'b1);
    tick(19);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    out_ready = 1'b0;
    tick(1);
    op(64'hFFFF_0000_1234_5678, 64'd13, 1'b0, 1'b0, 0);

    for (int k = 0; k < 150; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: b = '0;
        1: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        2: b = 64'($urandom_range(1, 20));
        3: b = -64'($urandom_range(1, 20));
        4: b = b >> $urandom_range(0, 63);
        default: ;
      endcase
      op(a, b, s, w, $urandom_range(0, 3));
    end

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
